// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, TERC4 table, popcount and the
// signed running-disparity type used by the channel encoder.
package tmds_pkg;

    typedef logic signed [4:0] disp_t;

    localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = CTRL_TOK_00;
            2'b01:   t = CTRL_TOK_01;
            2'b10:   t = CTRL_TOK_10;
            default: t = CTRL_TOK_11;
        endcase
        return t;
    endfunction

    function automatic logic [9:0] terc4_encode(input logic [3:0] a);
        logic [9:0] t;
        case (a)
            4'h0:    t = 10'b1010011100;
            4'h1:    t = 10'b1001100011;
            4'h2:    t = 10'b1011100100;
            4'h3:    t = 10'b1011100010;
            4'h4:    t = 10'b0101110001;
            4'h5:    t = 10'b0100011110;
            4'h6:    t = 10'b0110001110;
            4'h7:    t = 10'b0100111100;
            4'h8:    t = 10'b1011001100;
            4'h9:    t = 10'b0100111001;
            4'hA:    t = 10'b0110011100;
            4'hB:    t = 10'b1011000110;
            4'hC:    t = 10'b1010001110;
            4'hD:    t = 10'b1001110001;
            4'hE:    t = 10'b0101100011;
            default: t = 10'b1011000011;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel-side bus of one TMDS channel encoder. aux_en_i/aux_i exist only
// when TMDS_TERC4_EN is defined.
interface tmds_encoder_if;
    logic       ce_i;
    logic       de_i;
    logic [7:0] d_i;
    logic [1:0] ctrl_i;
`ifdef TMDS_TERC4_EN
    logic       aux_en_i;
    logic [3:0] aux_i;
`endif
    logic [9:0] q_o;

`ifdef TMDS_TERC4_EN
    modport master (output ce_i, de_i, d_i, ctrl_i, aux_en_i, aux_i, input q_o);
    modport slave  (input ce_i, de_i, d_i, ctrl_i, aux_en_i, aux_i, output q_o);
`else
    modport master (output ce_i, de_i, d_i, ctrl_i, input q_o);
    modport slave  (input ce_i, de_i, d_i, ctrl_i, output q_o);
`endif
endinterface

// File: rtl/tmds_encoder.sv
// Two-stage DVI TMDS channel encoder (transition minimisation, then DC
// balance). Define TMDS_TERC4_EN to add HDMI TERC4 auxiliary periods.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    tmds_encoder_if.slave  bus
);

    // Transition-minimised 9-bit word; bit 8 flags XOR (1) or XNOR (0).
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] qm;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        return qm;
    endfunction

    logic [8:0] w_qm_p0;
    logic [8:0] r_qm_p1;
    logic       r_de_p1;
    logic [1:0] r_ctrl_p1;
`ifdef TMDS_TERC4_EN
    logic       r_aux_en_p1;
    logic [3:0] r_aux_p1;
`endif

    logic [3:0] w_n1m_p1;
    logic [3:0] w_n0m_p1;
    disp_t      w_diff_p1;
    logic [9:0] w_q_p1;
    disp_t      w_cnt_nxt_p1;

    logic [9:0] r_q_p2;
    disp_t      r_cnt_p2;

    assign w_qm_p0 = tmds_qm(bus.d_i);

    // ---- stage 0 -> 1: transition minimisation ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_de_p1     <= 1'b0;
            r_ctrl_p1   <= 2'b00;
`ifdef TMDS_TERC4_EN
            r_aux_en_p1 <= 1'b0;
`endif
        end else if (bus.ce_i) begin
            r_de_p1     <= bus.de_i;
            r_ctrl_p1   <= bus.ctrl_i;
`ifdef TMDS_TERC4_EN
            r_aux_en_p1 <= bus.aux_en_i;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (bus.ce_i) begin
            r_qm_p1  <= w_qm_p0;
`ifdef TMDS_TERC4_EN
            r_aux_p1 <= bus.aux_i;
`endif
        end
    end

    // ---- stage 1 -> 2: DC balance and symbol select ----
    always_comb begin
        w_n1m_p1     = popcount8(r_qm_p1[7:0]);
        w_n0m_p1     = 4'd8 - w_n1m_p1;
        w_diff_p1    = $signed({1'b0, w_n1m_p1}) - $signed({1'b0, w_n0m_p1});
        w_q_p1       = CTRL_TOK_00;
        w_cnt_nxt_p1 = '0;
        if (r_de_p1) begin
            if ((r_cnt_p2 == 5'sd0) || (w_n1m_p1 == w_n0m_p1)) begin
                w_q_p1       = {~r_qm_p1[8], r_qm_p1[8],
                                r_qm_p1[8] ? r_qm_p1[7:0] : ~r_qm_p1[7:0]};
                w_cnt_nxt_p1 = r_qm_p1[8] ? (r_cnt_p2 + w_diff_p1)
                                          : (r_cnt_p2 - w_diff_p1);
            end else if (((r_cnt_p2 > 5'sd0) && (w_n1m_p1 > w_n0m_p1)) ||
                         ((r_cnt_p2 < 5'sd0) && (w_n0m_p1 > w_n1m_p1))) begin
                w_q_p1       = {1'b1, r_qm_p1[8], ~r_qm_p1[7:0]};
                w_cnt_nxt_p1 = r_cnt_p2 + (r_qm_p1[8] ? 5'sd2 : 5'sd0) - w_diff_p1;
            end else begin
                w_q_p1       = {1'b0, r_qm_p1[8], r_qm_p1[7:0]};
                w_cnt_nxt_p1 = r_cnt_p2 + w_diff_p1 - (r_qm_p1[8] ? 5'sd0 : 5'sd2);
            end
`ifdef TMDS_TERC4_EN
        end else if (r_aux_en_p1) begin
            w_q_p1 = terc4_encode(r_aux_p1);
`endif
        end else begin
            w_q_p1 = ctrl_token(r_ctrl_p1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q_p2   <= CTRL_TOK_00;
            r_cnt_p2 <= '0;
        end else if (bus.ce_i) begin
            r_q_p2   <= w_q_p1;
            r_cnt_p2 <= w_cnt_nxt_p1;
        end
    end

    assign bus.q_o = r_q_p2;

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed bench for tmds_encoder; TERC4 vectors run when TMDS_TERC4_EN is defined.
module tb_tmds_encoder;
    import tmds_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    tmds_encoder_if u_if();

    tmds_encoder dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input logic ce, input logic de, input logic [7:0] d,
                        input logic [1:0] ctrl);
        u_if.ce_i   = ce;
        u_if.de_i   = de;
        u_if.d_i    = d;
        u_if.ctrl_i = ctrl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sym(input string tag, input logic [9:0] q, input int cnt);
        chk({tag, "_q"}, {22'd0, u_if.q_o}, {22'd0, q});
        chk({tag, "_cnt"}, 32'(dut.r_cnt_p2), cnt);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        u_if.ce_i   = 1'b1;
        u_if.de_i   = 1'b0;
        u_if.d_i    = 8'h00;
        u_if.ctrl_i = 2'b00;
`ifdef TMDS_TERC4_EN
        u_if.aux_en_i = 1'b0;
        u_if.aux_i    = 4'h0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_sym("reset", 10'b1101010100, 0);
        rst_n = 1'b1;
        step(1, 0, 8'h00, 2'b00);
        chk_sym("post_reset", 10'b1101010100, 0);

        step(1, 0, 8'h00, 2'b11); step(1, 0, 8'h00, 2'b11);
        chk_sym("ctrl11", 10'b1010101011, 0);
        step(1, 0, 8'h00, 2'b01); step(1, 0, 8'h00, 2'b01);
        chk_sym("ctrl01", 10'b0010101011, 0);
        step(1, 0, 8'h00, 2'b10); step(1, 0, 8'h00, 2'b10);
        chk_sym("ctrl10", 10'b0101010100, 0);

        step(1, 1, 8'h00, 2'b00);
        step(1, 1, 8'h00, 2'b00); chk_sym("disp0", 10'h100, -8);
        step(1, 1, 8'h00, 2'b00); chk_sym("disp1", 10'h3FF, 2);
        step(1, 0, 8'h00, 2'b00); chk_sym("disp2", 10'h100, -6);
        step(1, 0, 8'h00, 2'b00); chk_sym("disp_ctl", 10'b1101010100, 0);

        step(1, 1, 8'hFF, 2'b00);
        step(1, 0, 8'h00, 2'b00); chk_sym("xnor_ff", 10'h200, -8);
        step(1, 0, 8'h00, 2'b00); chk_sym("xnor_ctl", 10'b1101010100, 0);

        step(1, 1, 8'h1E, 2'b00);
        step(1, 1, 8'h00, 2'b00); chk_sym("n1eq4_d0lo", 10'h25F, 4);
        step(1, 0, 8'h00, 2'b00); chk_sym("caseC_pos", 10'h100, -4);
        step(1, 0, 8'h00, 2'b00);
        step(1, 1, 8'h55, 2'b00);
        step(1, 0, 8'h00, 2'b00); chk_sym("balanced55", 10'h133, 0);

        step(1, 1, 8'h00, 2'b00); chk_sym("stall_pre", 10'b1101010100, 0);
        step(1, 1, 8'h00, 2'b00); chk_sym("stall_s0", 10'h100, -8);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'hFF, 2'b11); chk_sym("stall_hold", 10'h100, -8);
        end
        step(1, 1, 8'h00, 2'b00); chk_sym("stall_s1", 10'h3FF, 2);
        step(1, 0, 8'h00, 2'b00); chk_sym("stall_s2", 10'h100, -6);
        step(1, 1, 8'h00, 2'b00); chk_sym("one_ctl", 10'b1101010100, 0);
        step(1, 0, 8'h00, 2'b00); chk_sym("restart", 10'h100, -8);
        step(1, 0, 8'h00, 2'b00);

        step(1, 1, 8'hFF, 2'b00);
        step(1, 0, 8'h00, 2'b00); chk_sym("tog0", 10'h200, -8);
        step(1, 1, 8'hFF, 2'b00); chk_sym("tog1", 10'b1101010100, 0);
        step(1, 0, 8'h00, 2'b00); chk_sym("tog2", 10'h200, -8);
        step(1, 0, 8'h00, 2'b00);

        step(1, 1, 8'h00, 2'b00);
        step(1, 1, 8'h00, 2'b00);
        step(1, 1, 8'h00, 2'b00); chk_sym("pre_rst", 10'h3FF, 2);
        #2 rst_n = 1'b0;
        #1 chk_sym("async_rst", 10'b1101010100, 0);
        rst_n = 1'b1;
        step(1, 0, 8'h00, 2'b00); chk_sym("after_rst", 10'b1101010100, 0);

`ifdef TMDS_TERC4_EN
        u_if.aux_en_i = 1'b1; u_if.aux_i = 4'h0;
        step(1, 0, 8'h00, 2'b00);
        u_if.aux_i = 4'hF;
        step(1, 0, 8'h00, 2'b00); chk_sym("terc4_0", 10'b1010011100, 0);
        step(1, 1, 8'h00, 2'b00); chk_sym("terc4_f", 10'b1011000011, 0);
        u_if.aux_en_i = 1'b0;
        step(1, 0, 8'h00, 2'b00); chk_sym("de_wins", 10'h100, -8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

Pixel-domain TMDS channel encoder, directly upstream of the 10-bit serializer. Each enabled cycle it converts one 8-bit video byte (DE high) or 2-bit control word (DE low) into a DC-balanced 10-bit symbol per DVI 1.0. It tracks running disparity across symbols and feeds the serializer's parallel input. One instance is used per TMDS channel.

## Interface
- No parameters; widths are fixed by the TMDS format.
- clk_i  in  1  pixel clock
- rst_ni  in  1  reset, asynchronous, active-low
- ce_i  in  1  clock enable; all state advances only when high
- de_i  in  1  data enable: 1 selects video, 0 selects control
- d_i  in  8  video byte, sampled when ce_i && de_i
- ctrl_i  in  2  control word {C1,C0}, sampled when ce_i && !de_i
- aux_en_i  in  1  TERC4 period select; present only with TMDS_TERC4_EN
- aux_i  in  4  TERC4 nibble; present only with TMDS_TERC4_EN
- q_o  out  10  encoded symbol, registered, q_o[0] transmitted first

## Operation
- Stage 1 (registered): compute n1 = popcount(d_i).
  - If n1>4, or n1==4 with d_i[0]==0, use XNOR: q_m[0]=d[0], q_m[i]=~(q_m[i-1]^d[i]), q_m[8]=0.
  - Otherwise use XOR: q_m[i]=q_m[i-1]^d[i], q_m[8]=1.
  - de, ctrl and aux are piped alongside q_m.
- Stage 2 (registered): n1m/n0m = popcounts of q_m[7:0]. cnt is a 5-bit signed running disparity, range −8..+8.
  - Case A, cnt==0 or n1m==n0m:
    - q = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
    - cnt += q_m[8] ? (n1m−n0m) : (n0m−n1m)
  - Case B, (cnt>0 && n1m>n0m) or (cnt<0 && n0m>n1m):
    - q = {1, q_m[8], ~q_m[7:0]}
    - cnt += 2·q_m[8] + (n0m−n1m)
  - Case C, otherwise:
    - q = {0, q_m[8], q_m[7:0]}
    - cnt += (n1m−n0m) − 2·~q_m[8]
- Control period (de=0): q_o set from ctrl: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011 (q_o[9:0]). cnt is forced to 0.
- Source priority: de_i > aux_en_i > control.
- All arithmetic is done in signed 5-bit, with popcounts zero-extended. Overflow cannot occur in legal operation.

## Timing
- Latency: 2 enabled cycles from input sample to q_o.
- ce_i low: every register, including cnt, holds its value. q_o is stable.
- Reset state: q_o=1101010100, cnt=0, stage-1 de=0, ctrl=00, aux_en=0. Reset mid-stream takes effect immediately, with no glitch beyond the async clear.
- de transition 1→0: the first control symbol appears 2 enabled cycles later. cnt reads 0 for the next video symbol.
- de transition 0→1: the first video symbol is encoded with cnt=0.
- de toggling every cycle is legal. Each symbol is encoded independently per the rules above.

## Configuration
- TMDS_TERC4_EN defined:
  - Adds aux_en_i and aux_i.
  - When de_i=0 and aux_en_i=1, q_o is the HDMI TERC4 code for aux_i, listed as q_o[9:0] for 0..F: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
  - cnt is forced to 0 during TERC4 periods.
  - Latency is 2 enabled cycles.
- TMDS_TERC4_EN undefined: the ports are absent and the block is pure DVI.

## Structure
- Shared package tmds_pkg holds:
  - the 10-bit control token constants CTRL_TOK_00..11
  - a terc4_encode() function with the table above
  - a popcount8() function
  - the typedef disp_t (logic signed [4:0])
- No sub-module. The encoder is a single two-stage module; the serializer and tmds_encoder are instantiated side by side at top level.

## Test plan
- Reset: hold rst_ni=0 → q_o=1101010100, internal cnt=0. Release with de=0, ctrl=00 → q_o unchanged.
- Control: de=0, ctrl=11 for 2 ce cycles → q_o=1010101011. Repeat for ctrl=01 → 0010101011 and ctrl=10 → 0101010100.
- Disparity: from cnt=0, feed d=0x00 three times with de=1 → q_o sequence 0x100, 0x3FF, 0x100, cnt sequence −8, +2, −6.
- XNOR path: from cnt=0, d=0xFF → q_o=0x200, cnt=−8.
- Stall and return to control: stream 0x00 and insert ce_i=0 for 5 cycles → q_o and cnt frozen, sequence resumes unchanged. Then de=0 for one symbol followed by d=0x00 → q_o=0x100 (cnt restarted from 0).
- TERC4 (macro on): de=0, aux_en=1, aux=0x0 then 0xF → q_o=1010011100 then 1011000011. Assert de=1 during aux_en=1 → video encoding wins.
